// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter.
package uart_arb_pkg;

    localparam int unsigned BYTE_W = 8;

    // Arbiter FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t StIdle     = 2'd0;  // accept a byte
    localparam state_t StStart    = 2'd1;  // tx_start pulse
    localparam state_t StWaitAck  = 2'd2;  // wait for tx_busy to rise
    localparam state_t StWaitDone = 2'd3;  // wait for tx_busy to fall

    // Increment an index modulo n; n need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first valid index at or above ptr, modulo N.
module rr_picker #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            hit_o,
    output logic [IdxW-1:0] idx_o
);

    // Scan N positions starting at ptr, wrapping at N rather than at 2**IdxW
    always_comb begin
        int unsigned pos;
        logic [IdxW-1:0] p;
        hit_o = 1'b0;
        idx_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            p = IdxW'(pos);
            if (!hit_o && valid_i[p]) begin
                hit_o = 1'b1;
                idx_o = p;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of a single UART transmitter.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned LOCK_TIMEOUT = 270_000,
    localparam int unsigned IdxW        = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      n_reset_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*BYTE_W-1:0]   req_data_i,
    input  logic [N_REQ-1:0]          req_last_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      tx_start_o,
    output logic [BYTE_W-1:0]         tx_data_o,
    input  logic                      tx_busy_i,
    output logic [IdxW-1:0]           grant_id_o,
    output logic                      locked_o,
    output logic                      lock_timeout_o
);

    localparam int unsigned CntW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic              locked_q, locked_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
    logic              tx_start_q, tx_start_d;
    logic              lock_to_q, lock_to_d;

    logic              pick_hit;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   cand;
    logic              cand_valid;
    logic              to_fire;
    logic              xfer;

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .hit_o   (pick_hit),
        .idx_o   (pick_idx)
    );

    // Candidate selection: the lock owner only, otherwise the round-robin pick
    always_comb begin
        cand       = locked_q ? grant_q : pick_idx;
        cand_valid = locked_q ? req_valid_i[grant_q] : pick_hit;
    end

    // Timeout takes priority over an owner byte arriving in the same cycle
    assign to_fire = (LOCK_TIMEOUT != 32'd0) && (state_q == StIdle) && locked_q &&
                     (idle_cnt_q == CntW'(LOCK_TIMEOUT - 32'd1));
    assign xfer    = (state_q == StIdle) && cand_valid && !to_fire;

    // One-hot ready to the candidate; held low while reset is asserted
    always_comb begin
        req_ready_o = '0;
        if (xfer && n_reset_i) begin
            req_ready_o[cand] = 1'b1;
        end
    end

    // Next-state logic for FSM, lock, round-robin pointer and idle counter
    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        idle_cnt_d = '0;
        tx_start_d = 1'b0;
        lock_to_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (to_fire) begin
                    locked_d  = 1'b0;
                    rr_ptr_d  = IdxW'(wrap_inc(32'(grant_q), N_REQ));
                    lock_to_d = 1'b1;
                end else if (xfer) begin
                    data_d     = req_data_i[cand*BYTE_W +: BYTE_W];
                    grant_d    = cand;
                    tx_start_d = 1'b1;
                    state_d    = StStart;
                    if (req_last_i[cand]) begin
                        locked_d = 1'b0;
                        rr_ptr_d = IdxW'(wrap_inc(32'(cand), N_REQ));
                    end else begin
                        locked_d = 1'b1;
                    end
                end else if (locked_q) begin
                    // Owner is stalling while holding the lock
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            StStart:    state_d = StWaitAck;
            StWaitAck:  if (tx_busy_i)  state_d = StWaitDone;
            StWaitDone: if (!tx_busy_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q    <= StIdle;
            locked_q   <= 1'b0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            data_q     <= '0;
            idle_cnt_q <= '0;
            tx_start_q <= 1'b0;
            lock_to_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            idle_cnt_q <= idle_cnt_d;
            tx_start_q <= tx_start_d;
            lock_to_q  <= lock_to_d;
        end
    end

    assign tx_start_o     = tx_start_q;
    assign tx_data_o      = data_q;
    assign grant_id_o     = grant_q;
    assign locked_o       = locked_q;
    assign lock_timeout_o = lock_to_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single mother-board UART transmitter between `N_REQ` byte-stream requesters (CPU store port, boot/debug monitor, etc.) using round-robin arbitration with packet locking. A requester keeps the transmitter until it sends a byte flagged `last`, or until it stalls for `LOCK_TIMEOUT` cycles. The block sits between the requesters and the transmitter's start/busy interface, inside `mother_board`.

## Interface
- `N_REQ`, 2: number of requesters; must be at least 2.
- `LOCK_TIMEOUT`, 270_000: idle cycles before a held lock is force-released (10 ms at 27 MHz). A value of 0 disables the timeout.

- `clk`  in  1  system clock.
- `n_reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a byte.
- `req_data`  in  N_REQ*8  byte of requester i, in bits [8i+7:8i].
- `req_last`  in  N_REQ  the byte is the final byte of its packet.
- `req_ready`  out  N_REQ  byte of requester i accepted this cycle.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte to the transmitter; held stable from the start pulse until the byte completes.
- `tx_busy`  in  1  transmitter busy, from the start bit through the stop bit.
- `grant_id`  out  $clog2(N_REQ)  requester owning the current byte or lock.
- `locked`  out  1  a packet lock is held.
- `lock_timeout`  out  1  one-cycle pulse when a lock is force-released.

## Operation
- FSM states, defined in the package:
  - IDLE: accept a byte.
  - START: drive `tx_start`.
  - WAIT_ACK: wait for `tx_busy` to go high.
  - WAIT_DONE: wait for `tx_busy` to go low.
- IDLE, lock held: the only candidate is `grant_id`.
- IDLE, no lock: the candidate is the first i with `req_valid[i]=1`, searching from `rr_ptr` upward modulo N_REQ.
- `req_ready[cand]` is driven combinationally in IDLE only. A transfer is `req_valid & req_ready`. At most one `req_ready` bit is high, and it is never high outside IDLE.
- On transfer:
  - latch the byte into `tx_data`; set `grant_id` to cand; go to START.
  - If `req_last=0`: set `locked`.
  - If `req_last=1`: clear `locked` and set `rr_ptr` to (cand+1) mod N_REQ.
- START: `tx_start=1` for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: on `tx_busy=1`, go to WAIT_DONE. There is no timeout in this state.
- WAIT_DONE: on `tx_busy=0`, go to IDLE.
- Lock timeout:
  - `idle_cnt` increments in IDLE while `locked=1` and `req_valid[grant_id]=0`.
  - It clears on any transfer and in every other state.
  - When `idle_cnt` reaches LOCK_TIMEOUT-1: clear `locked`, set `rr_ptr` to `grant_id`+1 modulo N_REQ, and pulse `lock_timeout`. Arbitration resumes the next cycle.
- Wrap-around: `rr_ptr` wraps modulo N_REQ. This holds when N_REQ is not a power of 2.
- Simultaneous events:
  - If the owner's valid rises in the same cycle the timeout fires, the timeout wins and no transfer happens that cycle.
  - Requests from non-owners are ignored while locked.
- Reset, including mid-byte:
  - state=IDLE, `locked=0`, `rr_ptr=0`, `grant_id=0`, `tx_data=8'h00`, `idle_cnt=0`.
  - `tx_start=0`, `req_ready=0`, `lock_timeout=0`.
  - The transmitter's own reset aborts any frame in flight.

## Timing
- Transfer in cycle t:
  - `tx_start=1` in cycle t+1.
  - `tx_data` is valid from t+1 until the return to IDLE.
- Transmitter busy rising at t+2:
  - WAIT_DONE from t+3.
  - IDLE one cycle after `tx_busy` falls.
  - Next `req_ready` can assert in that same cycle.
- Throughput: one byte per transmitter frame plus 3 cycles of overhead.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, `locked`, `grant_id`, `rr_ptr` and state.

## Structure
- Package `uart_arb_pkg`:
  - `state_t` enum (IDLE, START, WAIT_ACK, WAIT_DONE).
  - `BYTE_W=8`.
- Sub-module `rr_picker`:
  - Parameter: N.
  - Inputs: `valid[N]`, `ptr`.
  - Outputs: `hit`, `idx`.
  - Purely combinational priority rotate. Reused by future bus arbiters.
- `uart_tx_arbiter` holds the FSM, the lock, `idle_cnt` and `rr_ptr`.
- Instantiation in `mother_board`: replace the direct transmitter connection with this block, transmitter `WAIT` unchanged.

## Test plan
- Single byte: N_REQ=2, req0 sends 8'h41 with last=1.
  - Expect `tx_start` pulse 1 cycle after `req_ready[0]`, `tx_data=8'h41` held until busy falls, `locked` never set, `rr_ptr`→1.
- Fairness: both requesters continuously valid, every byte last=1.
  - Expect grants alternate 0,1,0,1 over 8 bytes.
- Packet lock: req0 sends 8'h10,8'h11,8'h12 (last on the third byte) while req1 is valid throughout.
  - Expect all three req0 bytes before any req1 byte, then req1 granted.
- Lock timeout: LOCK_TIMEOUT=16; req0 sends one byte with last=0 then drops valid; req1 is valid.
  - Expect `lock_timeout` pulse exactly 16 IDLE cycles after return to IDLE.
  - Expect `req_ready[1]` the next cycle.
- Timeout/valid collision: req0 valid rises in the timeout cycle.
  - Expect no transfer that cycle; req1 wins the following cycle.
- Reset mid-frame: assert `n_reset=0` during WAIT_DONE with `locked=1`.
  - Expect all outputs at reset values immediately, with no `tx_start` until a new transfer.
